// File: rtl/soc_trace_retire_capture.sv
// ---------------------------------------------------------------------------
// soc_trace_retire_capture
//
// Purpose:
//   Snoops a CPU core's retire port and register-file write port and presents
//   one registered trace beat per retired instruction (PC, instruction word
//   and a coherent copy of GPR r3). Also counts retired instructions and runs
//   a stall watchdog so a hung core can be flagged. Simulation/bench use only;
//   one instance per core.
//
// Parameters:
//   R3_ADDR          GPR index that is shadowed
//   WATCHDOG_CYCLES  idle cycles before a stall is flagged (0 = disabled)
//   EXIT_INSN        instruction word whose retirement disarms the watchdog
//
// Ports:
//   i_clk            core clock
//   i_rst_n          asynchronous active-low reset
//   i_retire_valid   one instruction retires this cycle
//   i_retire_pc      PC of the retiring instruction
//   i_retire_insn    word of the retiring instruction
//   i_rf_we          register-file write strobe
//   i_rf_waddr       register-file write address
//   i_rf_wdata       register-file write data
//   o_trace_enable   beat valid
//   o_trace_pc       PC of the presented beat
//   o_trace_insn     instruction word of the presented beat
//   o_trace_r3       r3 value as seen at retirement
//   o_retire_count   total retired instructions (wraps modulo 2^32)
//   o_stall_detect   one-cycle pulse when the watchdog expires
//   o_stall_active   level: the core is currently considered stalled
// ---------------------------------------------------------------------------
module soc_trace_retire_capture #(
    parameter logic [4:0]  R3_ADDR         = 5'd3,
    parameter int unsigned WATCHDOG_CYCLES = 1024,
    parameter logic [31:0] EXIT_INSN       = 32'h1500_0001
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_retire_valid,
    input  logic [31:0] i_retire_pc,
    input  logic [31:0] i_retire_insn,
    input  logic        i_rf_we,
    input  logic [4:0]  i_rf_waddr,
    input  logic [31:0] i_rf_wdata,
    output logic        o_trace_enable,
    output logic [31:0] o_trace_pc,
    output logic [31:0] o_trace_insn,
    output logic [31:0] o_trace_r3,
    output logic [31:0] o_retire_count,
    output logic        o_stall_detect,
    output logic        o_stall_active
);

    localparam logic [31:0] WD_LIMIT   = 32'(WATCHDOG_CYCLES);
    localparam logic        WD_ENABLED = (WATCHDOG_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_STALLED  = 2'd1,
        ST_DISARMED = 2'd2
    } wd_state_t;

    logic        r_trace_enable;
    logic [31:0] r_trace_pc;
    logic [31:0] r_trace_insn;
    logic [31:0] r_trace_r3;
    logic [31:0] r_shadow_r3;
    logic [31:0] r_retire_count;
    logic [31:0] r_idle_cnt;
    logic        r_stall_detect;
    logic        r_stall_active;
    wd_state_t   r_state;

    logic        w_r3_hit;
    logic [31:0] w_fwd_r3;
    logic        w_exit_retire;
    logic [31:0] w_idle_inc;
    wd_state_t   w_state_next;
    logic [31:0] w_idle_next;
    logic        w_detect_next;

    assign w_r3_hit      = i_rf_we && (i_rf_waddr == R3_ADDR);
    // A write landing in the retire cycle has completed by retirement, so
    // forward it instead of the (stale) shadow copy.
    assign w_fwd_r3      = w_r3_hit ? i_rf_wdata : r_shadow_r3;
    assign w_exit_retire = i_retire_valid && (i_retire_insn == EXIT_INSN);
    assign w_idle_inc    = r_idle_cnt + 32'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow_r3 <= '0;
        end else if (w_r3_hit) begin
            r_shadow_r3 <= i_rf_wdata;
        end
    end

    // Payload holds on idle cycles; the downstream monitor compares against
    // the previous PC and relies on that.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_trace_enable <= 1'b0;
            r_trace_pc     <= '0;
            r_trace_insn   <= '0;
            r_trace_r3     <= '0;
            r_retire_count <= '0;
        end else begin
            r_trace_enable <= i_retire_valid;
            if (i_retire_valid) begin
                r_trace_pc     <= i_retire_pc;
                r_trace_insn   <= i_retire_insn;
                r_trace_r3     <= w_fwd_r3;
                r_retire_count <= r_retire_count + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_ARMED;
            r_idle_cnt     <= '0;
            r_stall_detect <= 1'b0;
            r_stall_active <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_idle_cnt     <= w_idle_next;
            r_stall_detect <= w_detect_next;
            r_stall_active <= (w_state_next == ST_STALLED);
        end
    end

    // Watchdog next-state. The exit instruction wins over everything; a retire
    // in the cycle the limit would be reached clears the counter and
    // suppresses the pulse because the retire test comes first.
    always_comb begin
        w_state_next  = r_state;
        w_idle_next   = r_idle_cnt;
        w_detect_next = 1'b0;
        if (w_exit_retire) begin
            w_state_next = ST_DISARMED;
            w_idle_next  = '0;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (i_retire_valid || !WD_ENABLED) begin
                        w_idle_next = '0;
                    end else if (w_idle_inc == WD_LIMIT) begin
                        w_idle_next   = WD_LIMIT;
                        w_detect_next = 1'b1;
                        w_state_next  = ST_STALLED;
                    end else begin
                        w_idle_next = w_idle_inc;
                    end
                end
                ST_STALLED: begin
                    if (i_retire_valid) begin
                        w_idle_next  = '0;
                        w_state_next = ST_ARMED;
                    end else begin
                        w_idle_next = WD_LIMIT;
                    end
                end
                ST_DISARMED: begin
                    w_idle_next = '0;
                end
                default: begin
                    w_state_next = ST_ARMED;
                    w_idle_next  = '0;
                end
            endcase
        end
    end

    assign o_trace_enable = r_trace_enable;
    assign o_trace_pc     = r_trace_pc;
    assign o_trace_insn   = r_trace_insn;
    assign o_trace_r3     = r_trace_r3;
    assign o_retire_count = r_retire_count;
    assign o_stall_detect = r_stall_detect;
    assign o_stall_active = r_stall_active;

endmodule

// File: tb/tb_soc_trace_retire_capture.sv
// ---------------------------------------------------------------------------
// tb_soc_trace_retire_capture
//
// Purpose:
//   Self-checking bench for soc_trace_retire_capture. Drives directed and
//   $urandom stimulus into two instances (watchdog limit 8 and watchdog
//   disabled) and compares every output against a behavioural model that
//   tracks the expected beat, retire total and the length of the current
//   idle streak.
// ---------------------------------------------------------------------------
module tb_soc_trace_retire_capture;

    localparam int          K    = 8;
    localparam logic [31:0] EXIT = 32'h1500_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        retireValid = 1'b0;
    logic [31:0] retirePc = '0;
    logic [31:0] retireInsn = '0;
    logic        rfWe = 1'b0;
    logic [4:0]  rfWaddr = '0;
    logic [31:0] rfWdata = '0;

    logic        trEnable, trEnable0;
    logic [31:0] trPc, trPc0;
    logic [31:0] trInsn, trInsn0;
    logic [31:0] trR3, trR30;
    logic [31:0] retCount, retCount0;
    logic        stDetect, stDetect0;
    logic        stActive, stActive0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        mEnable;
    logic [31:0] mPc, mInsn, mR3, mShadow, mCount;
    int          mIdle;
    bit          mDisarmed;

    always #5 clk = ~clk;

    soc_trace_retire_capture #(
        .R3_ADDR(5'd3), .WATCHDOG_CYCLES(K), .EXIT_INSN(EXIT)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_retire_valid(retireValid), .i_retire_pc(retirePc), .i_retire_insn(retireInsn),
        .i_rf_we(rfWe), .i_rf_waddr(rfWaddr), .i_rf_wdata(rfWdata),
        .o_trace_enable(trEnable), .o_trace_pc(trPc), .o_trace_insn(trInsn),
        .o_trace_r3(trR3), .o_retire_count(retCount),
        .o_stall_detect(stDetect), .o_stall_active(stActive)
    );

    soc_trace_retire_capture #(
        .R3_ADDR(5'd3), .WATCHDOG_CYCLES(0), .EXIT_INSN(EXIT)
    ) dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_retire_valid(retireValid), .i_retire_pc(retirePc), .i_retire_insn(retireInsn),
        .i_rf_we(rfWe), .i_rf_waddr(rfWaddr), .i_rf_wdata(rfWdata),
        .o_trace_enable(trEnable0), .o_trace_pc(trPc0), .o_trace_insn(trInsn0),
        .o_trace_r3(trR30), .o_retire_count(retCount0),
        .o_stall_detect(stDetect0), .o_stall_active(stActive0)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mEnable   = 1'b0;
        mPc       = '0;
        mInsn     = '0;
        mR3       = '0;
        mShadow   = '0;
        mCount    = '0;
        mIdle     = 0;
        mDisarmed = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        logic expDetect, expActive;
        expDetect = !mDisarmed && (mIdle == K);
        expActive = !mDisarmed && (mIdle >= K);
        checkVal({tag, ".enable"}, 32'(trEnable), 32'(mEnable));
        checkVal({tag, ".pc"}, trPc, mPc);
        checkVal({tag, ".insn"}, trInsn, mInsn);
        checkVal({tag, ".r3"}, trR3, mR3);
        checkVal({tag, ".count"}, retCount, mCount);
        checkVal({tag, ".detect"}, 32'(stDetect), 32'(expDetect));
        checkVal({tag, ".active"}, 32'(stActive), 32'(expActive));
        checkVal({tag, ".wd0_enable"}, 32'(trEnable0), 32'(mEnable));
        checkVal({tag, ".wd0_r3"}, trR30, mR3);
        checkVal({tag, ".wd0_detect"}, 32'(stDetect0), 32'd0);
        checkVal({tag, ".wd0_active"}, 32'(stActive0), 32'd0);
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model from
    // the sampled inputs, then check outputs 1 time unit after the edge.
    task automatic applyStimulus(input string tag, input logic v, input logic [31:0] pc,
                                 input logic [31:0] insn, input logic we,
                                 input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        retireValid = v;
        retirePc    = pc;
        retireInsn  = insn;
        rfWe        = we;
        rfWaddr     = wa;
        rfWdata     = wd;
        @(posedge clk);
        if (v) begin
            mEnable = 1'b1;
            mPc     = pc;
            mInsn   = insn;
            mR3     = (we && wa == 5'd3) ? wd : mShadow;
            mCount  = mCount + 32'd1;
            mIdle   = 0;
            if (insn == EXIT) mDisarmed = 1'b1;
        end else begin
            mEnable = 1'b0;
            if (mIdle < 1000000) mIdle++;
        end
        if (we && wa == 5'd3) mShadow = wd;
        #1;
        checkOutput(tag);
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic retire(input string tag, input logic [31:0] pc, input logic [31:0] insn);
        applyStimulus(tag, 1'b1, pc, insn, 1'b0, '0, '0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n       = 1'b0;
        retireValid = 1'b0;
        rfWe        = 1'b0;
        modelReset();
        #1;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic        v, we;
        logic [4:0]  wa;
        logic [31:0] insn;

        modelReset();
        doReset();

        // Basic beats with r3 forwarded in the retire cycle
        retire("beat0", 32'h100, 32'h9C60_0041);
        applyStimulus("beat1_fwd", 1'b1, 32'h104, 32'h1500_0004, 1'b1, 5'd3, 32'h0A);
        idle("hold");
        applyStimulus("wr_r3", 1'b0, '0, '0, 1'b1, 5'd3, 32'h41);
        retire("r3_shadow", 32'h108, 32'h1500_0004);
        applyStimulus("wr_r4", 1'b1, 32'h10C, 32'h1500_0004, 1'b1, 5'd4, 32'h99);

        // Retire on the 8th idle edge suppresses the pulse
        retire("wd_pre", 32'h200, 32'h0);
        for (int i = 0; i < K - 1; i++) idle("wd_idle_a");
        retire("wd_race", 32'h204, 32'h0);
        // Full expiry, then stalled level until next retire
        for (int i = 0; i < K + 4; i++) idle("wd_idle_b");
        retire("wd_recover", 32'h208, 32'h0);

        // Randomized traffic with mixed idle bursts and register writes
        for (int i = 0; i < 300; i++) begin
            v    = ($urandom_range(0, 9) < ((i / 40) % 2 == 0 ? 7 : 1));
            we   = $urandom_range(0, 1) == 1;
            wa   = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'd3;
            insn = $urandom();
            if (insn == EXIT) insn = insn ^ 32'h1;
            applyStimulus("rand", v, $urandom(), insn, we, wa, $urandom());
        end

        // Counter wrap
        @(negedge clk);
        force dut.r_retire_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_retire_count;
        mCount = 32'hFFFF_FFFE;
        retire("wrap0", 32'h300, 32'h1);
        retire("wrap1", 32'h304, 32'h2);
        retire("wrap2", 32'h308, 32'h3);
        checkVal("wrap_final", retCount, 32'h0000_0001);

        // Disarm, then idle well past the limit
        retire("disarm", 32'h400, EXIT);
        for (int i = 0; i < 100; i++) idle("disarmed_idle");

        // After reset the watchdog is live again
        doReset();
        retire("rearm", 32'h500, 32'h0);
        for (int i = 0; i < K + 1; i++) idle("rearm_idle");

        // Reset asserted mid-burst: outputs clear at once, nothing after release
        retire("burst0", 32'h600, 32'hA);
        retire("burst1", 32'h604, 32'hB);
        @(negedge clk);
        retireValid = 1'b1;
        retirePc    = 32'h608;
        retireInsn  = 32'hC;
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset");
        @(negedge clk);
        retireValid = 1'b0;
        rst_n       = 1'b1;
        idle("post_reset_idle");
        idle("post_reset_idle2");
        retire("post_reset_beat", 32'h700, 32'hD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
